// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences the shared memory/ALU datapath with a mem_ready stall handshake.
// Optional feature macro ILLEGAL_TRAP_EN: unsupported opcodes trap into HALT and set the sticky illegal flag.
module mips_multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           instr_done,
  output logic           illegal,
  output logic [STW-1:0] state
);

  localparam logic [STW-1:0] S_IDLE    = STW'(0);
  localparam logic [STW-1:0] S_FETCH   = STW'(1);
  localparam logic [STW-1:0] S_DECODE  = STW'(2);
  localparam logic [STW-1:0] S_MEMADR  = STW'(3);
  localparam logic [STW-1:0] S_MEMRD   = STW'(4);
  localparam logic [STW-1:0] S_MEMWB   = STW'(5);
  localparam logic [STW-1:0] S_MEMWR   = STW'(6);
  localparam logic [STW-1:0] S_EXECUTE = STW'(7);
  localparam logic [STW-1:0] S_ALUWB   = STW'(8);
  localparam logic [STW-1:0] S_BRANCH  = STW'(9);
  localparam logic [STW-1:0] S_ADDIEX  = STW'(10);
  localparam logic [STW-1:0] S_ADDIWB  = STW'(11);
  localparam logic [STW-1:0] S_JUMP    = STW'(12);
  localparam logic [STW-1:0] S_HALT    = STW'(13);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  logic [STW-1:0] next_state;
  logic           pc_write;
  logic           branch;

  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

`ifdef ILLEGAL_TRAP_EN
  logic op_legal;

  always_comb begin
    op_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
               (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
  end

  // Sticky until reset; set on the same edge that enters HALT
  always_ff @(posedge CLK) begin
    if (reset)                              illegal <= 1'b0;
    else if (state == S_DECODE && !op_legal) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      next_state = S_HALT;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:   if (mem_ready) next_state = S_FETCH;
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:    next_state = S_HALT;
`endif
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench: builds the expected per-cycle trace of each instruction from its class and wait counts, then checks the DUT cycle by cycle.
module tb_mips_multicycle_ctrl;
  logic       CLK = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, instr_done, illegal;
  logic [3:0] state;

  mips_multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic pcen, done, ill;
  } vec_t;

  typedef struct {
    int         st;
    bit         rst;
    bit         mr;
    bit         z;
    logic [5:0] op;
  } ent_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

  ent_t       q[$];
  logic [5:0] op_cur;
  int         total = 0;
  int         bad = 0;
  bit         pin_first = 0;
  vec_t       dv;

  assign dv = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, instr_done, illegal};

  // Outputs each named step must show, straight from the step table
  function automatic vec_t model(ent_t e);
    vec_t v = '0;
    v.st = 4'(e.st);
    case (e.st)
      1:  begin v.alusrcb = 2'b01; v.irwrite = e.mr; v.pcen = e.mr; end
      2:  v.alusrcb = 2'b11;
      3:  begin v.alusrca = 1; v.alusrcb = 2'b10; end
      4:  v.iord = 1;
      5:  begin v.memtoreg = 1; v.regwrite = 1; v.done = 1; end
      6:  begin v.iord = 1; v.memwrite = 1; v.done = e.mr; end
      7:  begin v.alusrca = 1; v.aluop = 2'b10; end
      8:  begin v.regdst = 1; v.regwrite = 1; v.done = 1; end
      9:  begin v.alusrca = 1; v.aluop = 2'b01; v.pcsrc = 2'b01; v.pcen = e.z; v.done = 1; end
      10: begin v.alusrca = 1; v.alusrcb = 2'b10; end
      11: begin v.regwrite = 1; v.done = 1; end
      12: begin v.pcsrc = 2'b10; v.pcen = 1; v.done = 1; end
      13: v.ill = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  task automatic push(int st, bit mr);
    ent_t e;
    e.st = st; e.rst = 0; e.mr = mr; e.z = 1'($urandom); e.op = op_cur;
    q.push_back(e);
  endtask

  task automatic step(ent_t e, string tag);
    vec_t ex;
    @(negedge CLK);
    reset = e.rst; mem_ready = e.mr; zero = e.z; opcode = e.op;
    #1;
    ex = model(e);
    total++;
    if (dv !== ex) begin
      bad++;
      $display("FAIL %s step=%0d: got %h expected %h", tag, e.st, dv, ex);
    end
  endtask

  task automatic pin(string tag, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // zsel: 0/1 forces zero in BRANCH, 2 random; abort: reset lands mid-instruction
  task automatic run_instr(int cls, int fw, int mw, int zsel, bit abort, string tag);
    int cnt, lat, nmw, base, cut;
    bit got_done;
    ent_t e;
    q.delete();
    case (cls)
      C_LW:   op_cur = 6'b100011;
      C_SW:   op_cur = 6'b101011;
      C_R:    op_cur = 6'b000000;
      C_BEQ:  op_cur = 6'b000100;
      C_ADDI: op_cur = 6'b001000;
      C_J:    op_cur = 6'b000010;
      default: begin
        op_cur = 6'b111111;
        if ($urandom_range(0, 1) == 1)
          do op_cur = 6'($urandom); while (is_legal(op_cur));
      end
    endcase
    for (int i = 0; i < fw; i++) push(1, 0);
    push(1, 1);
    push(2, 1'($urandom));
    case (cls)
      C_LW: begin
        push(3, 1'($urandom));
        for (int i = 0; i < mw; i++) push(4, 0);
        push(4, 1);
        push(5, 1'($urandom));
      end
      C_SW: begin
        push(3, 1'($urandom));
        for (int i = 0; i < mw; i++) push(6, 0);
        push(6, 1);
      end
      C_R:    begin push(7, 1'($urandom)); push(8, 1'($urandom)); end
      C_BEQ: begin
        push(9, 1'($urandom));
        if (zsel < 2) q[q.size()-1].z = zsel[0];
      end
      C_ADDI: begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
      C_J:    push(12, 1'($urandom));
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) push(13, 1'($urandom));
        q[q.size()-1].rst = 1;
        push(0, 1'($urandom));
`endif
      end
    endcase
    if (abort && cls != C_ILL) begin
      cut = $urandom_range(1, q.size() - 1);
      while (q.size() > cut) void'(q.pop_back());
      q[q.size()-1].rst = 1;
      push(0, 1'($urandom));
    end
    cnt = 0; lat = 0; nmw = 0; got_done = 0;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      step(e, tag);
      if (pin_first && i == 0) begin
        pin("first_fetch", {28'd0, state, IRWrite, PCEn}, 6'b000111);
        pin_first = 0;
      end
      cnt++;
      if (MemWrite === 1'b1) nmw++;
      if (!got_done && instr_done === 1'b1) begin got_done = 1; lat = cnt; end
    end
    case (cls)
      C_LW:         base = 5;
      C_SW, C_R, C_ADDI: base = 4;
      C_BEQ, C_J:   base = 3;
      default:      base = 0;
    endcase
    if (cls == C_ILL || abort) pin({tag, "_nodone"}, int'(got_done), 0);
    else begin
      pin({tag, "_latency"}, lat, base + fw + ((cls == C_LW || cls == C_SW) ? mw : 0));
      if (cls == C_SW) pin({tag, "_memwrite_cycles"}, nmw, mw + 1);
    end
  endtask

  initial begin
    ent_t e;
    int cls;
    reset = 1; mem_ready = 0; zero = 0; opcode = 6'b0; op_cur = 6'b0;
    e.st = 0; e.rst = 1; e.mr = 1; e.z = 1; e.op = 6'b100011;
    step(e, "reset0");
    step(e, "reset1");
    e.rst = 0;
    step(e, "idle");
    pin_first = 1;
    run_instr(C_LW,   0, 0, 2, 0, "lw");
    run_instr(C_SW,   0, 3, 2, 0, "sw_wait");
    run_instr(C_BEQ,  0, 0, 1, 0, "beq_taken");
    run_instr(C_BEQ,  0, 0, 0, 0, "beq_not_taken");
    run_instr(C_R,    0, 0, 2, 0, "rtype");
    run_instr(C_ADDI, 0, 0, 2, 0, "addi");
    run_instr(C_J,    0, 0, 2, 0, "jump");
    run_instr(C_LW,   2, 2, 2, 0, "lw_waits");
    run_instr(C_ILL,  0, 0, 2, 0, "illegal");
    run_instr(C_LW,   1, 1, 2, 1, "lw_abort");
    for (int n = 0; n < 300; n++) begin
      cls = ($urandom_range(0, 15) == 0) ? C_ILL : $urandom_range(0, 5);
      run_instr(cls, $urandom_range(0, 2), $urandom_range(0, 3), 2,
                $urandom_range(0, 15) == 0, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM that sequences a shared-memory multicycle MIPS datapath. It replaces the single-cycle control decode.
- Per instruction, one memory port and one ALU are time-shared across fetch, decode, execute, memory and writeback steps.
- Sits beside the datapath inside TOP_level: consumes opcode and ALU Zero, drives every mux select and write enable.
- Adds a mem_ready wait handshake so slow memories stall the sequence.

Parameters:
OPW, 6, opcode width
STW, 4, state register width (14 states used)

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  OPW  instr[31:26] from instruction register
zero  input  1  ALU Zero flag
mem_ready  input  1  memory completes access this cycle
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=Data register
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
ALUOp  output  2  to ALU decoder: 00 add, 01 sub, 10 funct
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
PCEn  output  1  PCWrite | (Branch & zero)
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal  output  1  sticky, unsupported opcode decoded
state  output  STW  current state, debug

Behaviour:
- Reset is synchronous, sampled on the CLK rising edge.
  - While reset=1: state<=IDLE(0), illegal<=0.
  - In IDLE, all outputs are 0.
  - IDLE -> FETCH unconditionally on the next edge with reset=0. Reset mid-instruction aborts to IDLE with no further writes.
- State encoding: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXECUTE7 ALUWB8 BRANCH9 ADDIEX10 ADDIWB11 JUMP12 HALT13. Codes 14–15 go to FETCH.
- Outputs per state (unlisted outputs = 0):
  - FETCH: ALUSrcB=01, IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH -> DECODE only when mem_ready=1, else hold.
  - DECODE dispatches on opcode:
    - 100011 lw / 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - other -> see ILLEGAL_TRAP_EN
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB when mem_ready, else hold.
  - MEMWR: hold with MemWrite=1 until mem_ready, then -> FETCH.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- instr_done=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR in the cycle mem_ready=1.
- PCEn is combinational from state and zero. BRANCH with zero=0 gives PCEn=0.
- Instruction latency with mem_ready tied 1:
  - beq, j: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- opcode is sampled only in DECODE and MEMADR. The IR is stable then because IRWrite=0 outside FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcode in DECODE -> HALT and sets illegal=1.
  - HALT drives all enables 0 and stays until reset.
- Undefined:
  - Unsupported opcode -> FETCH, treated as a NOP: no register or memory write, instr_done=0.
  - illegal is tied 0 and the HALT state is unreachable.

Test Plan:
- Reset held 2 cycles, then released:
  - state=0 with all outputs 0 during reset.
  - Next edge state=1.
  - With mem_ready=1: IRWrite=1, PCWrite=1, PCEn=1.
- lw (opcode 100011), mem_ready=1:
  - Expected state sequence 1,2,3,4,5,1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - Total 5 cycles.
- sw with mem_ready=0 for 3 cycles in MEMWR:
  - MemWrite=1 for 4 consecutive cycles.
  - instr_done only in the 4th; then FETCH.
- beq, zero=1 vs zero=0:
  - In BRANCH, PCSrc=01, ALUOp=01.
  - PCEn=1 vs PCEn=0.
- R-type, then addi, then j:
  - ALUWB has RegDst=1; ADDIWB has RegDst=0.
  - JUMP has PCSrc=10, PCEn=1.
  - Cycle counts 4/4/3.
- Opcode 111111:
  - With ILLEGAL_TRAP_EN: state=13, illegal=1, held for 10 cycles; reset recovers to state=0.
  - Without the macro: returns to FETCH, no writes.
